// File: rtl/stepper_dispense_seq.sv
// stepper_dispense_seq
//   Multi-channel stepper-motor dispense sequencer. Channels are served one at
//   a time. Each channel runs rounds[i] forward/reverse strokes of DEPTH steps
//   and is followed by a MOVE-tick idle gap. All motion advances on an
//   internal tick that fires once every STEP_DIV clock cycles.
//
//   Ports
//     clk        system clock
//     rst        asynchronous active-low reset
//     start      request a run (accepted only in IDLE when abort=0)
//     abort      cancel the run; the coils drop on the next edge
//     half_step  drive mode, latched on start (0 full-step, 1 half-step)
//     rounds     per-channel round counts, channel i at [i*CNT_W +: CNT_W]
//     busy       high while a run is in progress
//     done       one-cycle pulse on normal completion
//     cur_ch     channel being served
//     state_o    FSM state (0 IDLE, 1 DROP, 2 MOVE)
//     coils      coil pattern, channel i at [i*4 +: 4]
module stepper_dispense_seq #(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 10,
    parameter int STEP_DIV = 524288,
    parameter int DEPTH    = 8,
    parameter int MOVE     = 3,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    half_step,
    input  logic [N_CH*CNT_W-1:0]   rounds,
    output logic                    busy,
    output logic                    done,
    output logic [CH_W-1:0]         cur_ch,
    output logic [1:0]              state_o,
    output logic [N_CH*4-1:0]       coils
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int SW = $clog2(2 * DEPTH);
    localparam int GW = (MOVE > 1) ? $clog2(MOVE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DROP = 2'd1,
        S_MOVE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [SW-1:0]               s_q, s_d;
    logic [2:0]                  p_q, p_d;
    logic [CNT_W-1:0]            round_q, round_d, round_inc;
    logic [GW-1:0]               gap_q, gap_d;
    logic [N_CH-1:0][CNT_W-1:0]  rounds_q, rounds_d;
    logic                        half_q, half_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [CH_W-1:0]             cur_ch_q, cur_ch_d, nxt_ch;
    logic [N_CH*4-1:0]           coils_q, coils_d;
    logic                        tick;

    function automatic logic [3:0] phase_pattern(input logic [2:0] p, input logic hs);
        if (!hs) return 4'b0001 << p[1:0];
        case (p)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    // Full-step uses a 4-entry table, so bit 2 is forced low to wrap mod 4.
    function automatic logic [2:0] phase_step(input logic [2:0] p, input logic hs,
                                              input logic fwd);
        logic [2:0] n;
        n = fwd ? p + 3'd1 : p - 3'd1;
        if (!hs) n[2] = 1'b0;
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        p_d       = p_q;
        round_d   = round_q;
        gap_d     = gap_q;
        rounds_d  = rounds_q;
        half_d    = half_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cur_ch_d  = cur_ch_q;
        coils_d   = '0;
        tick      = (presc_q == PW'(STEP_DIV - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        round_inc = round_q + 1'b1;
        nxt_ch    = cur_ch_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    rounds_d = rounds;
                    half_d   = half_step;
                    cur_ch_d = '0;
                    presc_d  = '0;
                    busy_d   = 1'b1;
                    s_d      = '0;
                    p_d      = '0;
                    round_d  = '0;
                    gap_d    = '0;
                    state_d  = (rounds[CNT_W-1:0] != '0) ? S_DROP : S_MOVE;
                end
            end
            S_DROP: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    cur_ch_d = '0;
                    s_d      = '0;
                    p_d      = '0;
                    round_d  = '0;
                    gap_d    = '0;
                end else if (tick) begin
                    // First half of the stroke steps forward, second half back.
                    p_d = phase_step(p_q, half_q, s_q < SW'(DEPTH));
                    if (s_q == SW'(2 * DEPTH - 1)) begin
                        s_d = '0;
                        if (round_inc == rounds_q[cur_ch_q]) begin
                            round_d = '0;
                            gap_d   = '0;
                            state_d = S_MOVE;
                        end else begin
                            round_d = round_inc;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    cur_ch_d = '0;
                    s_d      = '0;
                    p_d      = '0;
                    round_d  = '0;
                    gap_d    = '0;
                end else if (tick) begin
                    if (gap_q == GW'(MOVE - 1)) begin
                        gap_d = '0;
                        if (cur_ch_q == CH_W'(N_CH - 1)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cur_ch_d = nxt_ch;
                            s_d      = '0;
                            p_d      = '0;
                            state_d  = (rounds_q[nxt_ch] != '0) ? S_DROP : S_MOVE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Coils are registered from the next state so they switch on the same
        // edge as the state/phase that selects them.
        for (int i = 0; i < N_CH; i++) begin
            if (state_d == S_DROP && cur_ch_d == CH_W'(i))
                coils_d[i*4 +: 4] = phase_pattern(p_d, half_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            s_q      <= '0;
            p_q      <= '0;
            round_q  <= '0;
            gap_q    <= '0;
            rounds_q <= '0;
            half_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cur_ch_q <= '0;
            coils_q  <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            s_q      <= s_d;
            p_q      <= p_d;
            round_q  <= round_d;
            gap_q    <= gap_d;
            rounds_q <= rounds_d;
            half_q   <= half_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cur_ch_q <= cur_ch_d;
            coils_q  <= coils_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cur_ch  = cur_ch_q;
    assign state_o = state_q;
    assign coils   = coils_q;

endmodule

// File: tb/tb_stepper_dispense_seq.sv
module tb_stepper_dispense_seq;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 3;
    localparam int STEP_DIV = 4;
    localparam int DEPTH    = 2;
    localparam int MOVE     = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic                  half_step;
    logic [N_CH*CNT_W-1:0] rounds;
    logic                  busy;
    logic                  done;
    logic [1:0]            cur_ch;
    logic [1:0]            state_o;
    logic [N_CH*4-1:0]     coils;

    int checks   = 0;
    int failures = 0;

    stepper_dispense_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV), .DEPTH(DEPTH), .MOVE(MOVE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .half_step(half_step),
        .rounds(rounds), .busy(busy), .done(done), .cur_ch(cur_ch),
        .state_o(state_o), .coils(coils)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference tables, written out from the drive-mode definitions.
    logic [3:0] full_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] half_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0100, 4'b1100, 4'b1000, 4'b1001};

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  ch;
        logic [11:0] coils;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int r0, r1, r2;
        bit hs;
        int cyc;
        bit poke;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One entry per tick interval: the outputs held between two tick edges.
    // Phase after k steps of a stroke is a triangle: k rising, then 2*DEPTH-k.
    task automatic build_model(input int r0, input int r1, input int r2, input bit hs);
        int r[3];
        exp_t e;
        int k;
        r = '{r0, r1, r2};
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) begin
            for (int rr = 0; rr < r[c]; rr++) begin
                for (int s = 0; s < 2 * DEPTH; s++) begin
                    k = (s <= DEPTH) ? s : 2 * DEPTH - s;
                    e.st    = 2'd1;
                    e.ch    = 2'(c);
                    e.coils = 12'(hs ? half_tab[k % 8] : full_tab[k % 4]) << (4 * c);
                    exp_q.push_back(e);
                end
            end
            for (int g = 0; g < MOVE; g++) begin
                e.st = 2'd2; e.ch = 2'(c); e.coils = '0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_check(input int r0, input int r1, input int r2, input bit hs,
                             input int exp_cyc, input bit poke, input string tag);
        int tot, done_at, ndone;
        exp_t e;
        build_model(r0, r1, r2, hs);
        tot = exp_q.size() * STEP_DIV;
        @(negedge clk);
        rounds    = {r2[CNT_W-1:0], r1[CNT_W-1:0], r0[CNT_W-1:0]};
        half_step = hs;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        done_at = -1;
        ndone   = 0;
        for (int k = 1; k <= tot + 20; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (k < tot) begin
                e = exp_q[k / STEP_DIV];
                chk($sformatf("%s_trace_k%0d", tag, k),
                    {state_o, cur_ch, busy, done, coils}, {e.st, e.ch, 1'b1, 1'b0, e.coils});
            end else if (k == tot) begin
                chk($sformatf("%s_end", tag), {state_o, busy, coils}, '0);
            end else if (k == tot + 1) begin
                chk($sformatf("%s_done_width", tag), 32'(done), 32'd0);
            end
            if (poke && k == 2 * STEP_DIV + 1) begin
                start     = 1'b1;
                rounds    = N_CH*CNT_W'($urandom);
                half_step = ~hs;
            end else if (poke && k == 2 * STEP_DIV + 2) begin
                start = 1'b0;
            end
        end
        chk($sformatf("%s_done_at", tag), 32'(done_at), 32'(exp_cyc));
        chk($sformatf("%s_done_count", tag), 32'(ndone), 32'd1);
    endtask

    task automatic coil_seq(input bit hs, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3, input logic [3:0] e4);
        logic [3:0] exp_a [5];
        exp_a = '{e0, e1, e2, e3, e4};
        @(negedge clk);
        rounds = {3'd0, 3'd0, 3'd1}; half_step = hs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((k - 1) % STEP_DIV == 0 && (k - 1) / STEP_DIV < 5)
                chk($sformatf("coilseq_hs%0d_j%0d", hs, (k - 1) / STEP_DIV),
                    32'(coils[3:0]), 32'(exp_a[(k - 1) / STEP_DIV]));
        end
    endtask

    task automatic count_done(input int cycles, input string tag);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(tag, 32'(n), 32'd0);
    endtask

    initial begin
        int r0, r1, r2, tot;
        bit hs, found;

        vecs[0] = '{r0: 1, r1: 0, r2: 2, hs: 1'b0, cyc: 60,  poke: 1'b0};
        vecs[1] = '{r0: 1, r1: 0, r2: 0, hs: 1'b1, cyc: 28,  poke: 1'b0};
        vecs[2] = '{r0: 0, r1: 0, r2: 0, hs: 1'b0, cyc: 12,  poke: 1'b0};
        vecs[3] = '{r0: 7, r1: 7, r2: 7, hs: 1'b0, cyc: 348, poke: 1'b1};
        vecs[4] = '{r0: 2, r1: 1, r2: 0, hs: 1'b1, cyc: 60,  poke: 1'b1};

        // Reset held with start asserted.
        rst = 1'b0; start = 1'b1; abort = 1'b0; half_step = 1'b0;
        rounds = {3'd1, 3'd1, 3'd1};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, cur_ch, state_o, coils}, '0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", {busy, state_o}, '0);

        for (int i = 0; i < 5; i++)
            run_check(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].hs, vecs[i].cyc,
                      vecs[i].poke, $sformatf("vec%0d", i));

        coil_seq(1'b0, 4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0000);
        coil_seq(1'b1, 4'b0001, 4'b0011, 4'b0010, 4'b0011, 4'b0000);

        // Abort during the channel-2 drop.
        @(negedge clk);
        rounds = {3'd2, 3'd0, 3'd1}; half_step = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (state_o == 2'd1 && cur_ch == 2'd2) found = 1'b1;
        end
        chk("abort_reach_ch2", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", {state_o, busy, done, cur_ch, coils}, '0);
        count_done(100, "abort_no_done");
        run_check(1, 0, 2, 1'b0, 60, 1'b0, "after_abort");

        // Start together with abort in IDLE is refused.
        @(negedge clk);
        rounds = {3'd1, 3'd1, 3'd1}; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_refused", {busy, state_o, coils}, '0);
        count_done(80, "start_abort_no_done");

        // Reset in the middle of a run.
        @(negedge clk);
        rounds = {3'd2, 3'd0, 3'd1}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_reset", {busy, done, cur_ch, state_o, coils}, '0);
        @(negedge clk);
        rst = 1'b1;
        count_done(100, "midrun_reset_no_done");

        // Randomised runs; done time from the run-length formula.
        for (int i = 0; i < 8; i++) begin
            r0 = $urandom_range(0, 3);
            r1 = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            hs = 1'($urandom_range(0, 1));
            tot = STEP_DIV * (2 * DEPTH * (r0 + r1 + r2) + N_CH * MOVE);
            run_check(r0, r1, r2, hs, tot, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
